// File: rtl/mem_arb.sv
// mem_arb -- two-port round-robin arbiter in front of a single memory port.
//
// Purpose: grants one of two requesters (p0 = CPU, p1 = debug/loader) access
// to memory, holds the granted request stable on mem_* until mem_ack or an
// 8-bit timeout, then pulses the owner's ack for one cycle.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   p0_req/we/addr/wdata           CPU request in
//   p0_ack/rdata/err/wait          CPU completion, read data, timeout, stall
//   p1_req/we/addr/wdata           debug port request in
//   p1_ack/rdata/err               debug port completion, read data, timeout
//   mem_req/we/addr/wdata          memory request out
//   mem_rdata, mem_ack             memory response in
//   busy                           FSM not idle
module mem_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   output logic        p0_wait,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   state_t      r_state;
   logic        r_owner;   // 0 = p0, 1 = p1
   logic        r_last;    // port served most recently
   logic [7:0]  r_cnt;
   logic        r_mem_req, r_mem_we;
   logic [31:0] r_mem_addr, r_mem_wdata;
   logic        r_p0_ack, r_p1_ack, r_p0_err, r_p1_err;
   logic [31:0] r_p0_rdata, r_p1_rdata;

   logic        w_any_req;
   logic        w_gnt;     // winning port index

   assign w_any_req = p0_req | p1_req;
   // On a tie the port not served last wins; otherwise the lone requester.
   assign w_gnt = (p0_req & p1_req) ? ~r_last : p1_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_cnt       <= 8'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_p0_ack    <= 1'b0;
         r_p1_ack    <= 1'b0;
         r_p0_err    <= 1'b0;
         r_p1_err    <= 1'b0;
         r_p0_rdata  <= 32'd0;
         r_p1_rdata  <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state     <= BUSY;
                  r_owner     <= w_gnt;
                  r_cnt       <= 8'd0;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_gnt ? p1_we    : p0_we;
                  r_mem_addr  <= w_gnt ? p1_addr  : p0_addr;
                  r_mem_wdata <= w_gnt ? p1_wdata : p0_wdata;
               end
            end
            BUSY: begin
               // mem_ack takes priority over a simultaneous timeout.
               if (mem_ack || r_cnt == 8'hFF) begin
                  r_state   <= DONE;
                  r_mem_req <= 1'b0;
                  r_last    <= r_owner;
                  if (r_owner) begin
                     r_p1_ack   <= 1'b1;
                     r_p1_err   <= ~mem_ack;
                     r_p1_rdata <= mem_ack ? mem_rdata : TIMEOUT_DATA;
                  end else begin
                     r_p0_ack   <= 1'b1;
                     r_p0_err   <= ~mem_ack;
                     r_p0_rdata <= mem_ack ? mem_rdata : TIMEOUT_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_state  <= IDLE;
               r_p0_ack <= 1'b0;
               r_p1_ack <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign p0_ack    = r_p0_ack;
   assign p1_ack    = r_p1_ack;
   assign p0_err    = r_p0_err;
   assign p1_err    = r_p1_err;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign p0_wait   = p0_req & ~r_p0_ack;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- directed self-checking bench for mem_arb.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p0_err, p0_wait, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_req, mem_we, mem_ack, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_arb dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err), .p0_wait(p0_wait),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
      tick(); tick();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_acks",    {30'd0, p0_ack, p1_ack}, 32'd0);
      chk("rst_errs",    {30'd0, p0_err, p1_err}, 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_p1_rdata", p1_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;

      // Basic p0 read, mem_ack in the first BUSY cycle.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010;
      tick();
      chk("rd_busy",     {31'd0, busy},    32'd1);
      chk("rd_mem_req",  {31'd0, mem_req}, 32'd1);
      chk("rd_mem_addr", mem_addr, 32'h0000_0010);
      chk("rd_mem_we",   {31'd0, mem_we},  32'd0);
      chk("rd_wait",     {31'd0, p0_wait}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      chk("rd_ack",      {30'd0, p0_ack, p1_ack}, 32'd2);
      chk("rd_rdata",    p0_rdata, 32'h1234_5678);
      chk("rd_err",      {31'd0, p0_err},  32'd0);
      chk("rd_done_req", {31'd0, mem_req}, 32'd0);
      chk("rd_done_wait",{31'd0, p0_wait}, 32'd0);
      p0_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      tick();
      chk("rd_idle",     {29'd0, busy, p0_ack, p1_ack}, 32'd0);
      chk("rd_hold",     p0_rdata, 32'h1234_5678);

      // Round-robin ties, starting from reset.
      rst = 1'b1; tick(); rst = 1'b0;
      p0_req = 1'b1; p0_addr = 32'h0000_0020;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_0030;
      tick();
      chk("rr1_addr", mem_addr, 32'h0000_0020);
      mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
      tick();
      chk("rr1_ack", {30'd0, p0_ack, p1_ack}, 32'd2);
      mem_ack = 1'b0; p0_req = 1'b0;
      tick();
      chk("rr1_idle", {31'd0, busy}, 32'd0);
      p0_req = 1'b1;
      tick();
      chk("rr2_addr", mem_addr, 32'h0000_0030);
      mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
      tick();
      chk("rr2_ack",   {30'd0, p0_ack, p1_ack}, 32'd1);
      chk("rr2_rdata", p1_rdata, 32'h0000_2222);
      chk("rr2_p0_hold", p0_rdata, 32'h0000_1111);
      mem_ack = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
      tick();

      // p1 write; owner's address changes mid-transfer.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0100; p1_wdata = 32'hCAFE_F00D;
      tick();
      chk("wr_we",    {31'd0, mem_we}, 32'd1);
      chk("wr_addr",  mem_addr,  32'h0000_0100);
      chk("wr_wdata", mem_wdata, 32'hCAFE_F00D);
      p1_addr = 32'h0000_0200; p1_wdata = 32'h0;
      tick();
      chk("wr_addr_stable", mem_addr, 32'h0000_0100);
      chk("wr_wdata_stable", mem_wdata, 32'hCAFE_F00D);
      chk("wr_req_held", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      tick();
      chk("wr_ack", {30'd0, p0_ack, p1_ack}, 32'd1);
      chk("wr_err", {31'd0, p1_err}, 32'd0);
      mem_ack = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
      tick();

      // p0 read with no mem_ack: timeout after 256 BUSY cycles.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0040;
      tick();
      chk("to_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (p0_ack !== 1'b1 && n < 300) begin
         if (p0_wait !== 1'b1) chk("to_wait", {31'd0, p0_wait}, 32'd1);
         tick();
         n++;
      end
      chk("to_cycles", n, 256);
      chk("to_ack",   {31'd0, p0_ack}, 32'd1);
      chk("to_err",   {31'd0, p0_err}, 32'd1);
      chk("to_rdata", p0_rdata, 32'hDEAD_BEEF);
      p0_req = 1'b0;
      tick();
      chk("to_err_hold", {31'd0, p0_err}, 32'd1);

      // Reset in the 3rd BUSY cycle aborts; held req then completes.
      p0_req = 1'b1; p0_addr = 32'h0000_0050;
      tick(); tick(); tick();
      chk("ab_busy3", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_mem_req", {31'd0, mem_req}, 32'd0);
      chk("ab_busy",    {31'd0, busy},    32'd0);
      chk("ab_ack",     {30'd0, p0_ack, p1_ack}, 32'd0);
      tick();
      chk("ab_regrant", mem_addr, 32'h0000_0050);
      mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
      tick();
      chk("ab_ack2",   {30'd0, p0_ack, p1_ack}, 32'd2);
      chk("ab_rdata",  p0_rdata, 32'hA5A5_5A5A);
      chk("ab_err",    {31'd0, p0_err}, 32'd0);
      p0_req = 1'b0; mem_ack = 1'b0;
      tick();

      // Stray mem_ack while idle.
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
      tick();
      chk("ia_state", {28'd0, busy, mem_req, p0_ack, p1_ack}, 32'd0);
      tick();
      chk("ia_state2", {28'd0, busy, mem_req, p0_ack, p1_ack}, 32'd0);
      chk("ia_rdata",  p0_rdata, 32'hA5A5_5A5A);
      mem_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 p0_req  input  1  CPU port request; held high until p0_ack seen.
REQ-004 p0_we  input  1  CPU port write enable (1 = write, 0 = read).
REQ-005 p0_addr  input  32  CPU port byte address.
REQ-006 p0_wdata  input  32  CPU port write data.
REQ-007 p0_ack  output  1  CPU port completion, one-cycle pulse.
REQ-008 p0_rdata  output  32  CPU port read data, valid while p0_ack is high and held until the next p0 completion.
REQ-009 p0_err  output  1  CPU port timeout flag, asserted together with p0_ack.
REQ-010 p0_wait  output  1  CPU stall, defined as p0_req & ~p0_ack (combinational).
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: debug/loader port; same directions, widths and meaning as the p0 signals.
REQ-012 mem_req  output  1  memory access request.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  32  memory address.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-017 mem_ack  input  1  memory completion.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-020 IDLE: if either req is high at a clock edge, the FSM SHALL go to BUSY and latch the winner's we, addr and wdata into the mem_* registers.
REQ-021 Arbitration SHALL be round-robin. When both reqs are high, the port not served last wins. After reset, "last served" SHALL be p1, so p0 wins the first tie.
REQ-022 BUSY: mem_req SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL stay stable from the latches.
REQ-023 BUSY with mem_ack = 1: capture mem_rdata into the owner's rdata register, clear the owner's err, update "last served", and go to DONE.
REQ-024 DONE: the owner's ack SHALL be 1 for exactly one cycle and mem_req SHALL be 0; the next state SHALL be IDLE.
REQ-025 Minimum latency: req sampled at edge N, mem_req high in cycle N+1, mem_ack high in cycle N+1, ack high in cycle N+2.
REQ-026 Requesters deassert req at the edge that samples ack high. A req that is high in IDLE SHALL be treated as a new request.
REQ-027 mem_ack SHALL be ignored in IDLE and DONE.
REQ-028 The arbiter SHALL keep an 8-bit timeout counter that clears on entry to BUSY and increments each BUSY cycle without mem_ack.
REQ-029 If the counter equals 255 while mem_ack = 0, the FSM SHALL go to DONE, load the owner's rdata with 32'hDEAD_BEEF, set the owner's err, and update "last served".
REQ-030 If mem_ack = 1 in the same cycle the counter reaches 255, mem_ack SHALL win (normal completion, err = 0).
REQ-031 A change on the non-owner's inputs during BUSY or DONE SHALL NOT affect the current transfer; that request waits in IDLE arbitration.
REQ-032 A change on the owner's addr, we or wdata after the grant SHALL NOT change the mem_* outputs.
REQ-033 Exactly one of p0_ack and p1_ack SHALL be high in DONE; both SHALL be 0 in all other states.

Reset
REQ-034 While rst is high at a clock edge, the FSM SHALL go to IDLE, and mem_req, mem_we, mem_addr, mem_wdata, p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err, busy and the timeout counter SHALL all be 0; "last served" SHALL be set to p1.
REQ-035 Reset during BUSY SHALL abort the transfer: mem_req is 0 from the next cycle and no ack is issued for the aborted request.

Verification
REQ-036 After reset, p0 read of 0x0000_0010, mem_ack in the first BUSY cycle with mem_rdata = 0x1234_5678 -> p0_ack pulse 2 cycles after the req edge, p0_rdata = 0x1234_5678, p0_err = 0.
REQ-037 p0 and p1 raise req in the same cycle twice in a row -> first grant p0, second grant p1; mem_addr matches each grantee.
REQ-038 p1 write to 0x0000_0100 with data 0xCAFE_F00D, and p1_addr changed to 0x0000_0200 during BUSY -> mem_we = 1 and mem_addr stays 0x0000_0100 until the ack; p1_ack pulses.
REQ-039 p0 read with mem_ack never asserted -> p0_ack and p0_err high after 256 BUSY cycles, p0_rdata = 0xDEAD_BEEF; p0_wait high throughout the wait.
REQ-040 rst asserted for 1 cycle in the 3rd BUSY cycle -> mem_req = 0, busy = 0 and no ack from the next cycle; a subsequent p0 request completes normally.
REQ-041 mem_ack pulsed while IDLE -> no ack and no state change.
